mist1032sa_sync_fifo_drain: RTL and testbench

MIST1032SA_SYNC_FIFO_DRAIN -- requirements
Module: mist1032sa_sync_fifo_drain

---
 rtl/mist1032sa_sync_fifo_drain.sv | 106 ++++++++++
 tb/tb_mist1032sa_sync_fifo_drain.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mist1032sa_sync_fifo_drain.sv
// rtl/mist1032sa_sync_fifo_drain.sv - two-entry skid drain from a FWFT sync FIFO to a busy/valid sink
// Drain counter is built only when MIST1032SA_SYNC_FIFO_DRAIN_COUNTER_EN is defined.
module mist1032sa_sync_fifo_drain #(
   parameter int N = 16
) (
   input  logic          iCLOCK,
   input  logic          iRESET_SYNC,
   input  logic          iFLUSH,
   input  logic          iFIFO_EMPTY,
   input  logic [N-1:0]  iFIFO_DATA,
   output logic          oFIFO_RD_EN,
   output logic          oDATA_VALID,
   output logic [N-1:0]  oDATA,
   input  logic          iDATA_BUSY,
   output logic [1:0]    oBUFFER_COUNT,
   output logic [31:0]   oDRAIN_COUNT
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [N-1:0]   entry0;
   logic [N-1:0]   entry1;
   logic [N-1:0]   entry0_next;
   logic [N-1:0]   entry1_next;
   logic           push;
   logic           pop;

   // Reset is folded in so nothing is popped or handed downstream in a reset cycle.
   assign push        = !iFIFO_EMPTY && !iFLUSH && !iRESET_SYNC && (state != TWO);
   assign oDATA_VALID = (state != EMPTY) && !iFLUSH && !iRESET_SYNC;
   assign pop         = oDATA_VALID && !iDATA_BUSY;

   assign oFIFO_RD_EN   = push;
   assign oDATA         = entry0;
   assign oBUFFER_COUNT = state;

   always_comb begin
      state_next  = state;
      entry0_next = entry0;
      entry1_next = entry1;
      case (state)
         EMPTY: begin
            if (push) begin
               state_next  = ONE;
               entry0_next = iFIFO_DATA;
            end
         end
         ONE: begin
            if (push && pop) begin
               entry0_next = iFIFO_DATA;
            end else if (push) begin
               state_next  = TWO;
               entry1_next = iFIFO_DATA;
            end else if (pop) begin
               state_next  = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_next  = ONE;
               entry0_next = entry1;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC || iFLUSH) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Data entries carry no reset; they are only observed while the state marks them valid.
   always_ff @(posedge iCLOCK) begin
      entry0 <= entry0_next;
      entry1 <= entry1_next;
   end

`ifdef MIST1032SA_SYNC_FIFO_DRAIN_COUNTER_EN
   logic [31:0] drain_count;

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         drain_count <= 32'h0;
      end else if (pop) begin
         drain_count <= drain_count + 32'h1;
      end
   end

   assign oDRAIN_COUNT = drain_count;
`else
   assign oDRAIN_COUNT = 32'h0;
`endif

endmodule

// File: tb/tb_mist1032sa_sync_fifo_drain.sv
// tb/tb_mist1032sa_sync_fifo_drain.sv - directed and random checks of the FIFO drain against a queue model
// Expected drain count follows MIST1032SA_SYNC_FIFO_DRAIN_COUNTER_EN.
module tb_mist1032sa_sync_fifo_drain;
   localparam int N = 16;

   logic          iCLOCK = 1'b0;
   logic          iRESET_SYNC = 1'b1;
   logic          iFLUSH = 1'b0;
   logic          iFIFO_EMPTY = 1'b1;
   logic [N-1:0]  iFIFO_DATA = '0;
   logic          oFIFO_RD_EN;
   logic          oDATA_VALID;
   logic [N-1:0]  oDATA;
   logic          iDATA_BUSY = 1'b0;
   logic [1:0]    oBUFFER_COUNT;
   logic [31:0]   oDRAIN_COUNT;

   int            compared = 0;
   int            mismatched = 0;
   logic [N-1:0]  up_q[$];
   logic [N-1:0]  m_buf[$];
   logic [N-1:0]  obs_q[$];
   logic [N-1:0]  exp_q[$];
   logic [31:0]   m_drain = 32'h0;
   logic [31:0]   saved_drain;

   always #5 iCLOCK = ~iCLOCK;

   mist1032sa_sync_fifo_drain #(.N(N)) dut (
      .iCLOCK        (iCLOCK),
      .iRESET_SYNC   (iRESET_SYNC),
      .iFLUSH        (iFLUSH),
      .iFIFO_EMPTY   (iFIFO_EMPTY),
      .iFIFO_DATA    (iFIFO_DATA),
      .oFIFO_RD_EN   (oFIFO_RD_EN),
      .oDATA_VALID   (oDATA_VALID),
      .oDATA         (oDATA),
      .iDATA_BUSY    (iDATA_BUSY),
      .oBUFFER_COUNT (oBUFFER_COUNT),
      .oDRAIN_COUNT  (oDRAIN_COUNT)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check outputs at the falling edge, then advance the model at the rising edge.
   task automatic cycle(input logic rst, input logic fl, input logic busy, input bit do_chk);
      logic e_rd;
      logic e_val;
      iRESET_SYNC = rst;
      iFLUSH      = fl;
      iDATA_BUSY  = busy;
      iFIFO_EMPTY = (up_q.size() == 0);
      iFIFO_DATA  = (up_q.size() != 0) ? up_q[0] : N'($urandom);
      @(negedge iCLOCK);
      e_rd  = (up_q.size() != 0) && !fl && !rst && (m_buf.size() < 2);
      e_val = (m_buf.size() != 0) && !fl && !rst;
      if (do_chk) begin
         chk("rd_en", 32'(oFIFO_RD_EN), 32'(e_rd));
         chk("data_valid", 32'(oDATA_VALID), 32'(e_val));
         chk("buffer_count", 32'(oBUFFER_COUNT), 32'(m_buf.size()));
         if (e_val) chk("data", 32'(oDATA), 32'(m_buf[0]));
         chk("drain_count", oDRAIN_COUNT, m_drain);
      end
      if (oDATA_VALID === 1'b1 && !busy) obs_q.push_back(oDATA);
      @(posedge iCLOCK);
      if (rst) begin
         m_buf.delete();
         m_drain = 32'h0;
      end else if (fl) begin
         m_buf.delete();
      end else begin
         if (e_val && !busy) begin
            void'(m_buf.pop_front());
`ifdef MIST1032SA_SYNC_FIFO_DRAIN_COUNTER_EN
            m_drain = m_drain + 32'h1;
`endif
         end
         if (e_rd) m_buf.push_back(up_q.pop_front());
      end
      #1;
   endtask

   initial begin
      // Reset with 0x1111 waiting upstream
      up_q.push_back(16'h1111);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk("reset_count", 32'(oBUFFER_COUNT), 32'h0);
      chk("reset_drain", oDRAIN_COUNT, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      chk("first_word", 32'(oDATA), 32'h1111);

      // Back-to-back stream of 8 words
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      obs_q.delete();
      for (int i = 1; i <= 8; i++) up_q.push_back(N'(i));
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("stream_n", 32'(obs_q.size()), 32'd8);
      for (int i = 0; i < obs_q.size(); i++) chk("stream_order", 32'(obs_q[i]), 32'(i + 1));
`ifdef MIST1032SA_SYNC_FIFO_DRAIN_COUNTER_EN
      chk("stream_drain", oDRAIN_COUNT, 32'd8);
`else
      chk("stream_drain", oDRAIN_COUNT, 32'd0);
`endif

      // Backpressure saturates the skid buffer, then releases in order
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         up_q.push_back(N'($urandom));
         exp_q.push_back(up_q[i]);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
      chk("busy_saturate", 32'(oBUFFER_COUNT), 32'd2);
      chk("busy_hold", 32'(oDATA), 32'(exp_q[0]));
      obs_q.delete();
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("release_n", 32'(obs_q.size()), 32'd8);
      for (int i = 0; i < obs_q.size(); i++) chk("release_order", 32'(obs_q[i]), 32'(exp_q[i]));

      // Flush with two words buffered
      for (int i = 0; i < 4; i++) up_q.push_back(N'($urandom));
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      chk("pre_flush_count", 32'(oBUFFER_COUNT), 32'd2);
      saved_drain = m_drain;
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      chk("flush_count", 32'(oBUFFER_COUNT), 32'd0);
      chk("flush_drain", oDRAIN_COUNT, saved_drain);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Drain counter wrap
`ifdef MIST1032SA_SYNC_FIFO_DRAIN_COUNTER_EN
      force dut.drain_count = 32'hFFFFFFFE;
      #1;
      release dut.drain_count;
      m_drain = 32'hFFFFFFFE;
`endif
      up_q.push_back(N'($urandom));
      up_q.push_back(N'($urandom));
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("wrap_drain", oDRAIN_COUNT, 32'h0);

      // Reset and flush together with two words buffered
      for (int i = 0; i < 3; i++) up_q.push_back(N'($urandom));
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      chk("pre_rstflush_count", 32'(oBUFFER_COUNT), 32'd2);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      chk("rstflush_count", 32'(oBUFFER_COUNT), 32'd0);
      chk("rstflush_drain", oDRAIN_COUNT, 32'h0);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 2) != 0) up_q.push_back(N'($urandom));
         cycle(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 24) == 0),
               1'($urandom_range(0, 1)), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
